// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a 4-entry FIFO and a drain interrupt
module uart_tx_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic en, ie, ovf;
  logic [15:0] baud, deff, div, bcnt;
  logic [7:0] fifo [4];
  logic [7:0] shift, shift_n;
  logic [1:0] rp, wp;
  logic [2:0] cnt, bit_idx;
  logic wr_ctrl, wr_baud, wr_data, full, empty, push, pop, last, unused;
  assign wr_ctrl = WE && Addr[1:0] == 2'd0;
  assign wr_baud = WE && Addr[1:0] == 2'd1;
  assign wr_data = WE && Addr[1:0] == 2'd2;
  assign full = cnt == 3'd4;
  assign empty = cnt == 3'd0;
  assign push = wr_data && !full;
  assign deff = baud == 16'd0 ? 16'd1 : baud;
  assign last = bcnt == div - 16'd1;
  assign pop = en && !empty && (state == IDLE || (state == STOP && last));
  assign shift_n = pop ? fifo[rp] : state == DATA && last ? shift >> 1 : shift;
  assign unused = ^{Addr[29:2], Din[31:16]};
  assign Dout = Addr[1:0] == 2'd0 ? {30'd0, ie, en}
              : Addr[1:0] == 2'd1 ? {16'd0, baud}
              : Addr[1:0] == 2'd3 ? {25'd0, ovf, cnt, empty, full, state != IDLE}
              : 32'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = pop ? START : IDLE;
      START: state_n = last ? DATA : START;
      DATA:  state_n = last && bit_idx == 3'd7 ? STOP : DATA;
      STOP:  state_n = pop ? START : last ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      en <= 1'b0;
      ie <= 1'b0;
      ovf <= 1'b0;
      baud <= 16'd16;
      div <= 16'd1;
      bcnt <= 16'd0;
      shift <= 8'd0;
      rp <= 2'd0;
      wp <= 2'd0;
      cnt <= 3'd0;
      bit_idx <= 3'd0;
      tx <= 1'b1;
      IRQ <= 1'b0;
    end else begin
      state <= state_n;
      {ie, en} <= wr_ctrl ? Din[1:0] : {ie, en};
      baud <= wr_baud ? Din[15:0] : baud;
      ovf <= !wr_ctrl && (ovf || (wr_data && full));
      div <= pop ? deff : div;
      bcnt <= state == IDLE || last ? 16'd0 : bcnt + 16'd1;
      bit_idx <= state != DATA ? 3'd0 : bit_idx + 3'(last);
      shift <= shift_n;
      rp <= rp + 2'(pop);
      wp <= wp + 2'(push);
      cnt <= cnt + 3'(push) - 3'(pop);
      tx <= state_n != START && (state_n != DATA || shift_n[0]);
      IRQ <= ie && empty && state == IDLE;
    end
  end
  always_ff @(posedge clk) if (push) fifo[wp] <= Din[7:0];
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench for uart_tx_dev with a line monitor decoding 8N1 frames
module tb_uart_tx_dev;
  logic clk = 0, reset = 1, WE = 0, IRQ, tx;
  logic [29:0] Addr = 0;
  logic [31:0] Din = 0, Dout;
  int checks = 0, errors = 0, cyc = 0, frames = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic [15:0] model_baud = 16;
  logic [1:0] model_ctrl = 0;
  logic model_ovf = 0, mon_busy = 0;
  int mon_d, bad, j;
  logic [7:0] mon_b, got;
  logic had, abort, e;
  uart_tx_dev dut (.clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ), .tx(tx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, g, x);
    end
  endtask
  task automatic model_reset();
    exp_q.delete();
    model_baud = 16;
    model_ctrl = 0;
    model_ovf = 0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din = d;
    WE = 1;
    if (a == 0) begin model_ctrl = d[1:0]; model_ovf = 0; end
    if (a == 1) model_baud = d[15:0];
    if (a == 2) begin
      if (exp_q.size() < 4) exp_q.push_back(d[7:0]);
      else model_ovf = 1;
    end
    @(negedge clk);
    WE = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'd0, a};
    #1 v = Dout;
  endtask
  function automatic logic [31:0] exp_status(input int n, input logic busy);
    return {25'd0, model_ovf, n[2:0], n == 0, n == 4, busy};
  endfunction
  task automatic do_reset();
    reset = 1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || mon_busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_start(input int s0);
    int n = 0;
    while (starts.size() <= s0 && n < 300) begin @(negedge clk); n++; end
    if (starts.size() <= s0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no start bit expected one within 300 cycles");
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      mon_busy = 1;
      starts.push_back(cyc);
      mon_d = model_baud == 0 ? 1 : int'(model_baud);
      had = exp_q.size() != 0;
      if (had) mon_b = exp_q.pop_front();
      else mon_b = 8'h00;
      bad = 0;
      got = 0;
      abort = 0;
      for (int i = 0; i < 10 * mon_d; i++) begin
        if (i > 0) @(negedge clk);
        if (reset) begin abort = 1; break; end
        j = i / mon_d;
        e = j == 0 ? 1'b0 : j == 9 ? 1'b1 : mon_b[j - 1];
        if (tx !== e) bad++;
        if (j >= 1 && j <= 8 && i % mon_d == 0) got[j - 1] = tx;
      end
      if (!had) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got frame at cycle %0d expected none", starts[starts.size() - 1]);
      end else if (!abort) begin
        checks++;
        frames++;
        if (bad != 0) begin
          errors++;
          $display("FAIL frame: got byte %02h with %0d wrong cycles expected %02h at divisor %0d", got, bad, mon_b, mon_d);
        end
      end
      mon_busy = 0;
    end
  end
  initial begin
    logic [31:0] v;
    int s0, busy_n, rise, n;
    do_reset();
    rd(0, v); chk("rst_ctrl", v, 32'h0);
    rd(1, v); chk("rst_baud", v, 32'h10);
    rd(2, v); chk("rst_data", v, 32'h0);
    rd(3, v); chk("rst_status", v, 32'h4);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_irq", 32'(IRQ), 0);
    wr(1, 2);
    wr(0, 1);
    s0 = starts.size();
    wr(2, 32'hA5);
    n = cyc;
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rd(3, v);
      busy_n += int'(v[0]);
    end
    chk("busy_cycles", busy_n, 20);
    chk("start_latency", starts.size() > s0 ? starts[s0] - n : -1, 1);
    drain();
    wr(1, 1);
    s0 = starts.size();
    wr(2, 1);
    wr(2, 2);
    wr(2, 3);
    drain();
    chk("b2b_frames", starts.size() - s0, 3);
    if (starts.size() - s0 == 3) begin
      chk("b2b_gap1", starts[s0 + 1] - starts[s0], 10);
      chk("b2b_gap2", starts[s0 + 2] - starts[s0 + 1], 10);
    end
    rd(3, v); chk("b2b_status", v, 32'h4);
    do_reset();
    for (int i = 0; i < 5; i++) wr(2, 32'h30 + i);
    rd(3, v); chk("ovf_status", v, 32'h62);
    wr(0, 1);
    rd(3, v); chk("ovf_clear", v, exp_status(4, 0));
    n = frames;
    drain();
    chk("ovf_frames", frames - n, 4);
    rd(3, v); chk("ovf_final", v, exp_status(0, 0));
    do_reset();
    wr(1, 1);
    wr(0, 3);
    @(negedge clk);
    chk("irq_idle", 32'(IRQ), 1);
    wr(2, $urandom & 255);
    chk("irq_at_write", 32'(IRQ), 1);
    rise = 0;
    for (int i = 1; i <= 20 && rise == 0; i++) begin
      @(negedge clk);
      if (i == 1) chk("irq_drop", 32'(IRQ), 0);
      if (IRQ) rise = i;
    end
    chk("irq_rise", rise, 12);
    wr(0, 1);
    chk("irq_ie_hold", 32'(IRQ), 1);
    @(negedge clk);
    chk("irq_ie_clear", 32'(IRQ), 0);
    drain();
    do_reset();
    wr(1, 4);
    wr(0, 1);
    s0 = starts.size();
    wr(2, 0);
    wait_start(s0);
    repeat (10) @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
    chk("mid_tx", 32'(tx), 1);
    rd(3, v); chk("mid_status", v, 32'h4);
    rd(0, v); chk("mid_ctrl", v, 32'h0);
    s0 = starts.size();
    repeat (60) @(negedge clk);
    chk("mid_no_frame", starts.size(), s0);
    do_reset();
    for (int it = 0; it < 6; it++) begin
      v = $urandom;
      v[15:0] = 16'($urandom_range(0, 3));
      wr(1, v);
      begin
        logic [31:0] r;
        rd(1, r);
        chk("rand_baud", r, {16'd0, v[15:0]});
      end
      wr(0, 1 | ($urandom & 2));
      n = $urandom_range(1, 4);
      s0 = starts.size();
      for (int k = 0; k < n; k++) begin
        wr(2, $urandom);
        if (it % 2 == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (it % 2 == 1) begin
        wait_start(s0);
        repeat (2) @(negedge clk);
        wr(1, $urandom_range(0, 3));
      end
      drain();
      rd(3, v); chk("rand_status", v, exp_status(0, 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter sitting behind the bridge as a bus responder alongside the two timers. It exposes the same `Addr`/`WE`/`Din`/`Dout`/`IRQ` device port shape as the timers. It accepts bytes from the CPU into a 4-entry FIFO and serialises them as 8N1 frames on `tx`. It raises a level interrupt into the CP0 hardware-interrupt vector when the transmitter drains.

## Interface
- No parameters; FIFO depth fixed at 4, frame format fixed at 8N1.
- `clk` in 1: the single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `Addr` in 30: word address (`br_dev_addr[31:2]`); only `Addr[1:0]` decoded.
- `WE` in 1: write strobe from bridge, one cycle per store.
- `Din` in 32: store data.
- `Dout` out 32: read data, combinational from `Addr`.
- `IRQ` out 1: level interrupt request.
- `tx` out 1: serial line, registered, idle high.

## Operation
- Register map by `Addr[1:0]`:
  - 0 CTRL: bit0 EN (transmit enable), bit1 IE (interrupt enable). R/W.
  - 1 BAUD: bits[15:0] divisor D; bits[31:16] read 0. R/W.
  - 2 DATA: write pushes `Din[7:0]`; reads 0.
  - 3 STATUS: read-only; writes ignored.
    - bit0 BUSY (FSM not IDLE).
    - bit1 FULL (count==4).
    - bit2 EMPTY (count==0).
    - bits[5:3] count (0..4).
    - bit6 OVF, sticky.
- Reset values: CTRL=0, BAUD=16, FIFO empty, OVF=0, FSM IDLE, `tx`=1, `IRQ`=0.
- Effective divisor: `Deff` = max(D,1). It is latched into a frame-local register when a frame starts. BAUD writes mid-frame affect only the next frame.
- FIFO: circular, 2-bit read/write pointers plus 3-bit count.
  - DATA write when FULL: data dropped, OVF set, count unchanged.
  - Simultaneous push and pop in the same cycle: both occur; count unchanged.
  - A write to CTRL clears OVF.
- FSM states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..Deff-1.
  - IDLE: if EN and !EMPTY, pop head into shift register, latch Deff, and go to START. `tx` is 0 from the next cycle.
  - START: hold `tx`=0 for Deff cycles, then go to DATA with bit index 0.
  - DATA: drive `tx`=shift[0] for Deff cycles, then shift right. After bit 7, go to STOP.
  - STOP: drive `tx`=1 for Deff cycles. At end:
    - If EN and !EMPTY, pop and go directly to START (back-to-back, no idle cycle).
    - Otherwise go to IDLE.
- Clearing EN mid-frame: the current frame completes; no further pops.
- `IRQ` = IE && EMPTY && state==IDLE, registered. It deasserts the cycle after any DATA write or IE clear takes effect.
- `Dout` is valid for any `Addr`. Unused offsets do not exist, since 2 bits map all 4.

## Timing
- DATA write sampled at edge N: count updates at N.
- First pop and START entry occur at edge N+1, so `tx` falls after N+1. Latency from store to start bit is 1 cycle when idle and enabled.
- Frame length is exactly 10·Deff cycles: start, 8 data bits LSB-first, stop.
- Next START begins immediately after the last STOP cycle.
- STATUS reflects state as of the last edge; a read in the write cycle sees the old count.
- `reset` asserted at any time, including mid-frame, returns every register to reset values at that edge. `tx`=1 from the next cycle; FIFO contents are discarded.

## Test plan
- Reset check: assert `reset` 2 cycles, then read all 4 offsets -> CTRL=0, BAUD=0x10, DATA=0, STATUS=0x4; `tx`=1, `IRQ`=0.
- Single frame: BAUD=2, CTRL=1, write DATA=0xA5 -> `tx` low 2 cycles starting 1 cycle after the write. Then bits 1,0,1,0,0,1,0,1 at 2 cycles each, stop high 2 cycles. BUSY=1 for exactly 20 cycles.
- Back-to-back: BAUD=1, CTRL=1, write 0x01,0x02,0x03 on consecutive cycles -> 30 contiguous frame cycles with no idle-high gap between stop and start. STATUS ends at 0x4.
- Overflow: CTRL=0, write 5 bytes -> STATUS=0x62 (FULL, count 4, OVF). Write CTRL=1 -> OVF cleared and 4 frames transmitted (first 4 bytes).
- Interrupt: CTRL=3, BAUD=1, one byte -> `IRQ` drops after the DATA write and rises 1 cycle after the FSM returns to IDLE. Clearing IE drops it the next cycle.
- Mid-frame reset: BAUD=4, start 0x00, assert `reset` at cycle 10 of the frame -> `tx`=1 next cycle, STATUS=0x4, no further frame.
